// File: rtl/lab1_sweep_ctrl_if.sv
// Signal bundle between the lab1 sweep sequencer and whoever requests runs
// and hosts the lab1 datapath being exercised.
interface lab1_sweep_ctrl_if;
    logic       start;
    logic       d_in;
    logic       a_out;
    logic       b_out;
    logic       c_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;

    // Requester / datapath side: issues start, returns D from lab1.
    modport master (
        output start,
        output d_in,
        input  a_out,
        input  b_out,
        input  c_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_mask
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  d_in,
        output a_out,
        output b_out,
        output c_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_mask
    );
endinterface

// File: rtl/lab1_sweep_ctrl.sv
// Self-test sequencer for the lab1 datapath (D = NOT majority(A,B,C)).
// Walks {A,B,C} through 0..7, holds each vector SETTLE cycles, samples D in
// the following cycle and records mismatches against EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start, results held
// DRIVE  | vector idx on A/B/C, counting settle cycles
// CHECK  | vector still driven, D sampled and compared
// FINISH | one-cycle done pulse, pass valid, A/B/C back to 000
module lab1_sweep_ctrl #(
    parameter logic [7:0]  EXPECTED = 8'h17,
    parameter int unsigned SETTLE   = 1          // legal range 1..15
) (
    input  logic             clk,
    input  logic             reset,
    lab1_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_wait;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic [7:0] r_mask;

    logic       w_mismatch;
    logic [3:0] w_err_next;

    // X/Z on d_in is treated as a failure so a floating datapath cannot pass.
    assign w_mismatch = (bus.d_in !== EXPECTED[r_idx]);
    assign w_err_next = r_err + {3'b000, w_mismatch};

    // Sweep FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_wait  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_mask  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= DRIVE;
                        r_idx   <= 3'd0;
                        r_wait  <= 4'd0;
                        r_err   <= 4'd0;
                        r_mask  <= 8'h00;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (r_wait == SETTLE_LAST) begin
                        r_state <= CHECK;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_err         <= w_err_next;
                        r_mask[r_idx] <= 1'b1;
                    end
                    if (r_idx == 3'd7) begin
                        // Include the last vector's result in pass.
                        r_state <= FINISH;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                    end else begin
                        r_state <= DRIVE;
                        r_idx   <= r_idx + 3'd1;
                        r_wait  <= 4'd0;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out     = r_idx[2];
    assign bus.b_out     = r_idx[1];
    assign bus.c_out     = r_idx[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_mask = r_mask;
endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// Directed bench for lab1_sweep_ctrl: one instance with SETTLE=1 driven by a
// switchable lab1 model (correct / inverted / stuck-0), and one with SETTLE=3
// driven by a correct model that can be glitched to X.
module tb_lab1_sweep_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       glitch;
    int         tests;
    int         fails;
    int         dones;

    lab1_sweep_ctrl_if bus1();
    lab1_sweep_ctrl_if bus2();

    lab1_sweep_ctrl #(.EXPECTED(8'h17), .SETTLE(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    lab1_sweep_ctrl #(.EXPECTED(8'h17), .SETTLE(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic nmaj(input logic a, input logic b, input logic c);
        return ~((a & b) | (a & c) | (b & c));
    endfunction

    // lab1 datapath models
    always_comb begin
        case (mode)
            2'd0:    bus1.d_in = nmaj(bus1.a_out, bus1.b_out, bus1.c_out);
            2'd1:    bus1.d_in = ~nmaj(bus1.a_out, bus1.b_out, bus1.c_out);
            default: bus1.d_in = 1'b0;
        endcase
    end

    always_comb begin
        if (glitch) bus2.d_in = 1'bx;
        else        bus2.d_in = nmaj(bus2.a_out, bus2.b_out, bus2.c_out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] st1();
        return {bus1.busy, bus1.done, bus1.a_out, bus1.b_out, bus1.c_out};
    endfunction

    function automatic logic [4:0] st2();
        return {bus2.busy, bus2.done, bus2.a_out, bus2.b_out, bus2.c_out};
    endfunction

    // Full SETTLE=1 run: start pulsed before edge k, sampled at each negedge.
    task automatic run1(input logic [1:0] m, input logic [3:0] e_err,
                        input logic [7:0] e_mask, input logic e_pass);
        mode = m;
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            check("run1 seq", 32'(st1()), {27'd0, 1'b1, 1'b0, 3'((j - 1) / 2)});
            @(negedge clk);
        end
        check("run1 done", 32'(st1()), 32'b01000);
        check("run1 err", 32'(bus1.err_count), 32'(e_err));
        check("run1 mask", 32'(bus1.fail_mask), 32'(e_mask));
        check("run1 pass", 32'(bus1.pass), 32'(e_pass));
        @(negedge clk);
        check("run1 post", 32'(st1()), 32'b00000);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        mode       = 2'd0;
        glitch     = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        check("reset st", 32'(st1()), 32'b00000);
        check("reset res", {19'd0, bus1.pass, bus1.err_count, bus1.fail_mask}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1-3: correct, inverted, stuck-0 datapaths
        run1(2'd0, 4'd0, 8'h00, 1'b1);
        run1(2'd1, 4'd8, 8'hFF, 1'b0);
        run1(2'd2, 4'd4, 8'h17, 1'b0);
        repeat (5) @(negedge clk);
        check("hold err", 32'(bus1.err_count), 32'd4);
        check("hold mask", 32'(bus1.fail_mask), 32'h17);

        // 4: start held until second done, then pulses during busy
        mode  = 2'd0;
        dones = 0;
        @(negedge clk) bus1.start = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (bus1.done) dones++;
            if (j == 17) check("held done1", 32'(bus1.done), 32'd1);
            if (j == 18) check("held gap", 32'(st1()), 32'b00000);
            if (j == 19) check("held v0", 32'(st1()), 32'b10000);
            if (j == 35) begin
                check("held done2", 32'(bus1.done), 32'd1);
                check("held pass2", 32'(bus1.pass), 32'd1);
                bus1.start = 1'b0;
            end
        end
        check("held count", 32'(dones), 32'd2);

        dones = 0;
        @(negedge clk) bus1.start = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            bus1.start = (j == 5 || j == 10 || j == 16);
            if (bus1.done) dones++;
        end
        bus1.start = 1'b0;
        check("busy start ign", 32'(dones), 32'd1);

        // 5: reset while vector 3 driven
        @(negedge clk) bus1.start = 1'b1;
        @(negedge clk) bus1.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre-reset v3", 32'(st1()), 32'b10011);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("mid reset st", 32'(st1()), 32'b00000);
        check("mid reset res", {19'd0, bus1.pass, bus1.err_count, bus1.fail_mask}, 32'd0);
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus1.done) dones++;
        end
        check("no done after rst", 32'(dones), 32'd0);
        run1(2'd0, 4'd0, 8'h00, 1'b1);

        // 6: SETTLE=3, X glitches on d_in while driving only
        @(negedge clk) bus2.start = 1'b1;
        @(negedge clk) bus2.start = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            check("s3 seq", 32'(st2()), {27'd0, 1'b1, 1'b0, 3'((j - 1) / 4)});
            glitch = (j == 1 || j == 3 || j == 13);
            @(negedge clk);
        end
        glitch = 1'b0;
        check("s3 done", 32'(st2()), 32'b01000);
        check("s3 pass", 32'(bus2.pass), 32'd1);
        check("s3 err", 32'(bus2.err_count), 32'd0);
        check("s3 mask", 32'(bus2.fail_mask), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
